// File: rtl/vga_pipe_pkg.sv
// Shared definitions for the VGA pipeline control slice.
// Holds the pipeline opcode encodings, the frame scheduler FSM state
// encodings and a small helper that maps a scheduler state to "busy".
package vga_pipe_pkg;

  // Operation applied by the pixel pipeline for a whole frame.
  typedef enum logic [1:0] {
    OP_PASS  = 2'b00,  // pass-through, pipeline idle
    OP_PIPE1 = 2'b01,
    OP_PIPE2 = 2'b10,
    OP_PIPE3 = 2'b11
  } opcode_t;

  // Frame scheduler states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10
  } sched_state_t;

  // The scheduler reports busy while an operation is waiting or running.
  function automatic logic state_is_busy(input sched_state_t st);
    case (st)
      ST_ARMED: return 1'b1;
      ST_RUN:   return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/op_frame_scheduler_if.sv
// Scheduler <-> pixel pipeline handshake.
//   active_opcode : opcode currently applied to the pipeline (scheduler drives)
//   pipe_start    : single-cycle start pulse to the pipeline (scheduler drives)
//   pipe_done     : single-cycle completion pulse from the pipeline
// master = scheduler side, slave = pipeline side.
interface op_frame_scheduler_if;
  import vga_pipe_pkg::*;

  opcode_t active_opcode;
  logic    pipe_start;
  logic    pipe_done;

  modport master (output active_opcode, output pipe_start, input pipe_done);
  modport slave  (input active_opcode, input pipe_start, output pipe_done);

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a debouncer.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   btn_in     : raw asynchronous button, active-high
//   btn_level  : debounced button level
//   btn_rise   : one-cycle pulse when btn_level goes 0->1 (release is silent)
// A new level is accepted after DEBOUNCE_CYCLES consecutive synchronized
// samples that all differ from the current level; a single sample equal to
// the current level restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          rise_r;
  logic [CW-1:0] cnt_r;
  logic          accept_s;

  // Accept when the current differing sample is the last one of the run.
  always_comb begin
    accept_s = (sync2_r != level_r) && (cnt_r == CNT_LAST);
  end

  // Synchronizer, stability counter, debounced level and rise pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
      rise_r  <= accept_s & sync2_r;
      if (sync2_r != level_r) begin
        if (accept_s) begin
          level_r <= sync2_r;
          cnt_r   <= CNT_ZERO;
        end else begin
          cnt_r   <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= CNT_ZERO;
      end
    end
  end

  assign btn_level = level_r;
  assign btn_rise  = rise_r;

endmodule

// File: rtl/op_frame_scheduler.sv
// Frame-synchronous operation scheduler for the VGA pixel pipeline.
// A debounced button press latches the requested opcode; the next frame
// boundary (v_sync falling) commits it to the pipeline with a start pulse.
// The running operation must finish within TIMEOUT_FRAMES frame boundaries
// or a sticky timeout error is raised.
// Ports:
//   clk, rst      : 25 MHz pixel clock, synchronous active-high reset
//   push_button   : raw asynchronous button, active-high
//   opcode        : requested pipeline operation
//   v_sync        : VGA vertical sync, active-low
//   busy          : high while ARMED or RUN
//   timeout_err   : sticky, cleared only by rst
//   pipe_bus      : active_opcode / pipe_start out, pipe_done in
module op_frame_scheduler
  import vga_pipe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMEOUT_FRAMES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_button,
  input  logic [1:0]            opcode,
  input  logic                  v_sync,
  output logic                  busy,
  output logic                  timeout_err,
  op_frame_scheduler_if.master  pipe_bus
);

  localparam int FW = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(TIMEOUT_FRAMES - 1);
  localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
  localparam logic [FW-1:0] FRAME_ZERO = FW'(0);

  sched_state_t  state_r;
  sched_state_t  state_nxt_s;
  logic          vsync_r;
  logic          btn_level_s;
  logic          btn_rise_s;
  logic          press_s;
  logic          frame_edge_s;
  logic          done_s;
  logic          timeout_s;
  logic          commit_s;
  opcode_t       opcode_in_s;
  opcode_t       commit_op_s;
  opcode_t       pending_op_r;
  opcode_t       active_op_r;
  logic          pipe_start_r;
  logic          busy_r;
  logic          timeout_err_r;
  logic          press_seen_r;
  logic [FW-1:0] frame_cnt_r;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (push_button),
    .btn_level (btn_level_s),
    .btn_rise  (btn_rise_s)
  );

  // Event decode: press, frame boundary, completion and timeout condition.
  always_comb begin
    // The rise pulse always coincides with the new high level.
    press_s      = btn_rise_s & btn_level_s;
    frame_edge_s = vsync_r & ~v_sync;
    done_s       = pipe_bus.pipe_done;
    opcode_in_s  = opcode_t'(opcode);
    // pipe_done in the same cycle wins over the expiring frame budget.
    timeout_s    = (state_r == ST_RUN) && frame_edge_s && !done_s &&
                   (frame_cnt_r == FRAME_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        // A frame edge in the press cycle does not commit from IDLE.
        if (press_s) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (frame_edge_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_RUN: begin
        if (done_s) begin
          if (press_seen_r || press_s) begin
            state_nxt_s = ST_ARMED;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: commit decision and drive of the registered outputs.
  always_comb begin
    commit_s = (state_r == ST_ARMED) && frame_edge_s;
    // A press in the commit cycle supersedes the previously latched opcode.
    if (press_s) begin
      commit_op_s = opcode_in_s;
    end else begin
      commit_op_s = pending_op_r;
    end
    pipe_bus.active_opcode = active_op_r;
    pipe_bus.pipe_start    = pipe_start_r;
    busy                   = busy_r;
    timeout_err            = timeout_err_r;
  end

  // Datapath registers: v_sync sample, opcodes, pulses, counters and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_r       <= 1'b1;
      pending_op_r  <= OP_PASS;
      active_op_r   <= OP_PASS;
      pipe_start_r  <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      press_seen_r  <= 1'b0;
      frame_cnt_r   <= FRAME_ZERO;
    end else begin
      vsync_r      <= v_sync;
      pipe_start_r <= commit_s;
      busy_r       <= state_is_busy(state_nxt_s);
      if (press_s) begin
        pending_op_r <= opcode_in_s;
      end else begin
        pending_op_r <= pending_op_r;
      end
      if (commit_s) begin
        active_op_r <= commit_op_s;
      end else begin
        active_op_r <= active_op_r;
      end
      if (timeout_s) begin
        timeout_err_r <= 1'b1;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
      // Remembers a press made while running so completion re-arms.
      if ((state_r == ST_RUN) && (state_nxt_s == ST_RUN)) begin
        press_seen_r <= press_seen_r | press_s;
      end else begin
        press_seen_r <= 1'b0;
      end
      // Saturates at FRAME_LAST; reaching it with another edge is the timeout.
      if (commit_s) begin
        frame_cnt_r <= FRAME_ZERO;
      end else if ((state_r == ST_RUN) && frame_edge_s &&
                   (frame_cnt_r != FRAME_LAST)) begin
        frame_cnt_r <= frame_cnt_r + FRAME_ONE;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_op_frame_scheduler.sv
// Directed testbench for op_frame_scheduler (DEBOUNCE_CYCLES=4, TIMEOUT_FRAMES=2).
// Press latency from a clean push_button rise, driven between edges:
//   2 synchronizer flops + 4 debounce samples -> debounced level and press
//   register updated on the 6th edge, FSM reacts to press on the 7th edge.
// frame_edge is seen on the first edge that samples v_sync low.
module tb_op_frame_scheduler;

  typedef struct {
    string      name;
    logic       push;
    logic [1:0] op;
    logic       vs;
    logic       done;
    int         cycles;
    logic       exp_busy;
    logic [1:0] exp_act;
    logic       exp_to;
    int         exp_starts;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       push_button;
  logic [1:0] opcode;
  logic       v_sync;
  logic       busy;
  logic       timeout_err;

  int   compared    = 0;
  int   mismatched  = 0;
  int   start_count = 0;
  int   base_starts;
  logic start_prev  = 1'b0;
  vec_t vecs[$];

  op_frame_scheduler_if bus ();

  op_frame_scheduler #(
    .DEBOUNCE_CYCLES (4),
    .TIMEOUT_FRAMES  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push_button (push_button),
    .opcode      (opcode),
    .v_sync      (v_sync),
    .busy        (busy),
    .timeout_err (timeout_err),
    .pipe_bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  // Advance n clock cycles and settle just past the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic add_vec(input string nm, input logic push, input logic [1:0] op,
                         input logic vs, input logic done, input int cyc,
                         input logic eb, input logic [1:0] ea, input logic et,
                         input int es);
    vec_t v;
    v.name = nm; v.push = push; v.op = op; v.vs = vs; v.done = done; v.cycles = cyc;
    v.exp_busy = eb; v.exp_act = ea; v.exp_to = et; v.exp_starts = es;
    vecs.push_back(v);
  endtask

  // Count start pulses and require each to last exactly one cycle.
  always @(negedge clk) begin
    if (start_prev === 1'b1) begin
      check("pipe_start_width", {31'd0, bus.pipe_start}, 32'd0);
    end
    if (bus.pipe_start === 1'b1) begin
      start_count++;
    end
    start_prev = bus.pipe_start;
  end

  initial begin
    // name, push, op, vs, done, cycles | busy, act, to, starts
    add_vec("bounce_hi",   1'b1, 2'b01, 1'b1, 1'b0,  2, 1'b0, 2'b00, 1'b0, 0);
    add_vec("bounce_lo",   1'b0, 2'b01, 1'b1, 1'b0,  2, 1'b0, 2'b00, 1'b0, 0);
    add_vec("stable_hi",   1'b1, 2'b01, 1'b1, 1'b0, 12, 1'b1, 2'b00, 1'b0, 0);
    add_vec("commit_01",   1'b1, 2'b01, 1'b0, 1'b0,  3, 1'b1, 2'b01, 1'b0, 1);
    add_vec("run_vs_hi",   1'b1, 2'b01, 1'b1, 1'b0,  5, 1'b1, 2'b01, 1'b0, 1);
    add_vec("done_idle",   1'b1, 2'b01, 1'b1, 1'b1,  1, 1'b0, 2'b01, 1'b0, 1);
    add_vec("release",     1'b0, 2'b01, 1'b1, 1'b0, 10, 1'b0, 2'b01, 1'b0, 1);
    add_vec("press_01",    1'b1, 2'b01, 1'b1, 1'b0,  8, 1'b1, 2'b01, 1'b0, 1);
    add_vec("commit_01b",  1'b1, 2'b01, 1'b0, 1'b0,  2, 1'b1, 2'b01, 1'b0, 2);
    add_vec("release_run", 1'b0, 2'b01, 1'b1, 1'b0,  8, 1'b1, 2'b01, 1'b0, 2);
    add_vec("press_10_run",1'b1, 2'b10, 1'b1, 1'b0,  9, 1'b1, 2'b01, 1'b0, 2);
    add_vec("done_rearm",  1'b1, 2'b10, 1'b1, 1'b1,  1, 1'b1, 2'b01, 1'b0, 2);
    add_vec("armed_wait",  1'b1, 2'b10, 1'b1, 1'b0,  3, 1'b1, 2'b01, 1'b0, 2);
    add_vec("commit_10",   1'b1, 2'b10, 1'b0, 1'b0,  2, 1'b1, 2'b10, 1'b0, 3);
    add_vec("to_vs_hi1",   1'b1, 2'b10, 1'b1, 1'b0,  3, 1'b1, 2'b10, 1'b0, 3);
    add_vec("to_frame1",   1'b1, 2'b10, 1'b0, 1'b0,  2, 1'b1, 2'b10, 1'b0, 3);
    add_vec("to_vs_hi2",   1'b1, 2'b10, 1'b1, 1'b0,  3, 1'b1, 2'b10, 1'b0, 3);
    add_vec("to_frame2",   1'b1, 2'b10, 1'b0, 1'b0,  2, 1'b0, 2'b10, 1'b1, 3);
    add_vec("done_in_idle",1'b1, 2'b10, 1'b1, 1'b1,  1, 1'b0, 2'b10, 1'b1, 3);
    add_vec("idle_wait",   1'b1, 2'b10, 1'b1, 1'b0,  2, 1'b0, 2'b10, 1'b1, 3);

    // Reset state
    rst = 1'b1; push_button = 1'b0; opcode = 2'b00; v_sync = 1'b1; bus.pipe_done = 1'b0;
    tick(3);
    check("rst_busy",        {31'd0, busy},           32'd0);
    check("rst_active",      {30'd0, bus.active_opcode}, 32'd0);
    check("rst_timeout",     {31'd0, timeout_err},    32'd0);
    check("rst_pipe_start",  {31'd0, bus.pipe_start}, 32'd0);
    rst = 1'b0;

    // Table: bounce, commit, completion, re-arm during RUN, timeout
    for (int i = 0; i < vecs.size(); i++) begin
      push_button   = vecs[i].push;
      opcode        = vecs[i].op;
      v_sync        = vecs[i].vs;
      bus.pipe_done = vecs[i].done;
      tick(vecs[i].cycles);
      check({vecs[i].name, "_busy"},   {31'd0, busy},              {31'd0, vecs[i].exp_busy});
      check({vecs[i].name, "_active"}, {30'd0, bus.active_opcode}, {30'd0, vecs[i].exp_act});
      check({vecs[i].name, "_timeout"},{31'd0, timeout_err},       {31'd0, vecs[i].exp_to});
      check({vecs[i].name, "_starts"}, start_count,                vecs[i].exp_starts);
    end

    // Timeout flag is cleared by reset only
    push_button = 1'b0;
    tick(8);
    check("to_sticky", {31'd0, timeout_err}, 32'd1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("to_cleared",     {31'd0, timeout_err},       32'd0);
    check("rst2_active",    {30'd0, bus.active_opcode}, 32'd0);
    check("rst2_busy",      {31'd0, busy},              32'd0);

    // Press and frame edge in the same IDLE cycle: arm only, commit next frame
    base_starts = start_count;
    opcode = 2'b11;
    push_button = 1'b1;
    tick(6);
    check("same_idle_pre_busy", {31'd0, busy}, 32'd0);
    v_sync = 1'b0;
    tick(1);
    check("same_idle_busy",  {31'd0, busy},           32'd1);
    check("same_idle_nostart", {31'd0, bus.pipe_start}, 32'd0);
    tick(3);
    check("same_idle_starts", start_count, base_starts);
    check("same_idle_active", {30'd0, bus.active_opcode}, 32'd0);
    v_sync = 1'b1;
    tick(3);
    v_sync = 1'b0;
    tick(1);
    check("next_frame_start",  {31'd0, bus.pipe_start},    32'd1);
    check("next_frame_active", {30'd0, bus.active_opcode}, 32'd3);
    tick(1);
    check("next_frame_start_end", {31'd0, bus.pipe_start}, 32'd0);
    check("next_frame_starts",    start_count, base_starts + 1);
    check("next_frame_busy",      {31'd0, busy}, 32'd1);

    // Reset in RUN abandons the operation; a late pipe_done is ignored
    push_button = 1'b0;
    v_sync = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    bus.pipe_done = 1'b1;
    tick(1);
    bus.pipe_done = 1'b0;
    tick(3);
    check("abandon_busy",    {31'd0, busy},              32'd0);
    check("abandon_active",  {30'd0, bus.active_opcode}, 32'd0);
    check("abandon_timeout", {31'd0, timeout_err},       32'd0);
    check("abandon_starts",  start_count, base_starts + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/op_frame_scheduler.md
OP_FRAME_SCHEDULER -- requirements
Module: op_frame_scheduler

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, cycles push_button must be stable before a level change is accepted (10 ms at 25 MHz).
REQ-002 SHALL have parameter TIMEOUT_FRAMES, default 4, frame boundaries allowed between pipe_start and pipe_done.
REQ-003 SHALL have port clk  input  1  pixel clock (25 MHz); sole clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port push_button  input  1  raw asynchronous button, active-high.
REQ-006 SHALL have port opcode  input  2  requested pipeline operation.
REQ-007 SHALL have port v_sync  input  1  VGA vertical sync from the VGA timing block, active-low.
REQ-008 SHALL have port pipe_done  input  1  single-cycle pulse from the pipeline when the frame operation completes.
REQ-009 SHALL have port active_opcode  output  2  opcode currently applied to the pipeline.
REQ-010 SHALL have port pipe_start  output  1  single-cycle start pulse to the pipeline.
REQ-011 SHALL have port busy  output  1  high in states ARMED and RUN.
REQ-012 SHALL have port timeout_err  output  1  sticky error flag.

Function
REQ-013 SHALL pass push_button through a 2-flop synchronizer before debouncing.
REQ-014 SHALL accept a new debounced level only after DEBOUNCE_CYCLES consecutive equal synchronized samples; the counter restarts on any sample mismatch.
REQ-015 SHALL generate press = one-cycle pulse on the debounced 0->1 transition; release generates nothing.
REQ-016 SHALL generate frame_edge = one-cycle pulse on the registered 1->0 transition of v_sync (v_sync registered once).
REQ-017 SHALL, on press, load opcode into pending_op in the same cycle, in any state.
REQ-018 SHALL implement FSM states IDLE, ARMED and RUN.
REQ-019 SHALL, in IDLE, transition on press to ARMED.
REQ-020 SHALL, in ARMED, on frame_edge: load active_opcode <= pending_op, pulse pipe_start for one cycle, clear the frame counter and transition to RUN.
REQ-021 SHALL, in RUN, on pipe_done, transition to ARMED if a press occurred during RUN, else to IDLE.
REQ-022 SHALL, in RUN, increment the frame counter on each frame_edge; on reaching TIMEOUT_FRAMES without pipe_done, set timeout_err and transition to IDLE.
REQ-023 SHALL, for press and frame_edge in the same IDLE cycle, move to ARMED only; the commit occurs at the next frame_edge.
REQ-024 SHALL, for press and frame_edge in the same ARMED cycle, commit the newly loaded opcode, i.e. the opcode present in that cycle.
REQ-025 SHALL, for pipe_done and frame_edge in the same RUN cycle, treat pipe_done as taking priority and not set timeout_err.
REQ-026 SHALL ignore pipe_done outside RUN.
REQ-027 SHALL keep multiple presses within one state last-wins.
REQ-028 SHALL change active_opcode only at a commit.
REQ-029 SHALL give pipe_start a latency of 1 cycle after the frame_edge cycle, registered.

Reset
REQ-030 SHALL, on rst, set state IDLE, active_opcode 2'b00, pending_op 2'b00, pipe_start 0, busy 0 and timeout_err 0.
REQ-031 SHALL, on rst, set the debounced level 0, clear the debounce and frame counters, and clear the synchronizer and v_sync registers to 0 and 1 respectively.
REQ-032 SHALL abandon an operation in RUN when rst is asserted mid-operation; a subsequent pipe_done SHALL be ignored.
REQ-033 SHALL clear timeout_err only by rst.

Structure
REQ-034 SHALL place the opcode encodings (00 pass-through, 01, 10, 11 per pipeline) and the FSM state encodings in shared package vga_pipe_pkg.
REQ-035 SHALL implement the synchronizer plus debounce as sub-module btn_debounce (ports clk, rst, btn_in, btn_level, btn_rise).
REQ-036 SHALL keep the FSM, edge detection and timeout in op_frame_scheduler.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_FRAMES=2)
REQ-037 Bench SHALL cover: button bounce 1,0,1 at 2-cycle spacing then stable 1 with opcode=2'b01 -> exactly one press; busy=1; at next v_sync fall active_opcode=2'b01 and one pipe_start pulse.
REQ-038 Bench SHALL cover: in RUN, pipe_done with no new press -> IDLE, busy=0, active_opcode holds 2'b01.
REQ-039 Bench SHALL cover: press with opcode=2'b10 during RUN, then pipe_done -> ARMED; next frame commits 2'b10.
REQ-040 Bench SHALL cover: no pipe_done over 2 v_sync falls -> timeout_err=1, IDLE; rst -> timeout_err=0.
REQ-041 Bench SHALL cover: press and v_sync fall in the same IDLE cycle -> no pipe_start that cycle; commit at the following frame.
REQ-042 Bench SHALL cover: rst asserted in RUN, then pipe_done -> remains IDLE, active_opcode=2'b00.
